// File: rtl/rs232_tx_arbiter.sv
// Two-source stb/ack arbiter feeding one UART transmitter; the grant is held for
// a whole line and released on the end-of-line character or after an idle timeout.
module rs232_tx_arbiter #(
  parameter int WIDTH = 32,
  parameter logic [7:0] EOL_CHAR = 8'h0A,
  parameter int TIMEOUT = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] input_a,
  input  logic             input_a_stb,
  output logic             input_a_ack,
  input  logic [WIDTH-1:0] input_b,
  input  logic             input_b_stb,
  output logic             input_b_ack,
  output logic [WIDTH-1:0] output_tx,
  output logic             output_tx_stb,
  input  logic             output_tx_ack,
  output logic             grant_b
);

  localparam int CW = (TIMEOUT > 0) ? (($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    SEND   = 2'd2
  } state_t;

  state_t          state;
  logic            ptr_b;
  logic [CW-1:0]   idle_cnt;
  logic            pick_b;
  logic            gnt_stb;
  logic [WIDTH-1:0] gnt_data;

  // B wins in IDLE only when A is quiet or the round-robin pointer favours B.
  assign pick_b   = input_b_stb && (!input_a_stb || ptr_b);
  assign gnt_stb  = grant_b ? input_b_stb : input_a_stb;
  assign gnt_data = grant_b ? input_b : input_a;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      output_tx     <= '0;
      output_tx_stb <= 1'b0;
      input_a_ack   <= 1'b0;
      input_b_ack   <= 1'b0;
      grant_b       <= 1'b0;
      idle_cnt      <= '0;
      ptr_b         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (input_a_stb || input_b_stb) begin
            grant_b     <= pick_b;
            input_a_ack <= !pick_b;
            input_b_ack <= pick_b;
            idle_cnt    <= '0;
            state       <= ACCEPT;
          end
        end

        ACCEPT: begin
          if (gnt_stb) begin
            output_tx     <= gnt_data;
            output_tx_stb <= 1'b1;
            input_a_ack   <= 1'b0;
            input_b_ack   <= 1'b0;
            idle_cnt      <= '0;
            state         <= SEND;
          end else if (TIMEOUT != 0 && idle_cnt == CNT_LAST) begin
            input_a_ack <= 1'b0;
            input_b_ack <= 1'b0;
            ptr_b       <= !grant_b;
            idle_cnt    <= '0;
            state       <= IDLE;
          end else if (idle_cnt != '1) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end

        SEND: begin
          if (output_tx_ack) begin
            output_tx_stb <= 1'b0;
            if (output_tx[7:0] == EOL_CHAR) begin
              ptr_b <= !grant_b;
              state <= IDLE;
            end else begin
              input_a_ack <= !grant_b;
              input_b_ack <= grant_b;
              idle_cnt    <= '0;
              state       <= ACCEPT;
            end
          end
        end

        default: begin
          input_a_ack   <= 1'b0;
          input_b_ack   <= 1'b0;
          output_tx_stb <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule
